// File: rtl/fsm_control_multilane.sv
// rtl/fsm_control_multilane.sv - multi-lane sprint start/timing controller with UART report queue
module fsm_control_multilane #(
    parameter int  N_LANES       = 4,
    parameter int  CLK_FREQ      = 25_000_000,
    parameter int  COUNT_READY   = CLK_FREQ * 2,
    parameter int  COUNT_SET     = CLK_FREQ * 2,
    parameter int  COUNT_GO      = CLK_FREQ * 1,
    parameter int  COUNT_TIMEOUT = CLK_FREQ * 60,
    parameter int  BLINK_HALF    = CLK_FREQ / 4,
    localparam int LANE_W        = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic               clk,
    input  logic               reset_global,
    input  logic               set_button_in,
    input  logic               abort_button_in,
    input  logic [N_LANES-1:0] lane_active_in,
    input  logic [N_LANES-1:0] sensor_start_in,
    input  logic [N_LANES-1:0] sensor_meta_in,
    input  logic               uart_busy_in,
    output logic               reset_timer_out,
    output logic [N_LANES-1:0] enable_timer_out,
    output logic [2:0]         semaforo_out,
    output logic               servo_out,
    output logic [N_LANES-1:0] false_start_out,
    output logic               race_done_out,
    output logic               tx_start_out,
    output logic [LANE_W-1:0]  tx_lane_out
);

    // Terminal counts are "last cycle" values so each phase lasts exactly COUNT_* cycles.
    localparam logic [31:0] READY_LAST   = 32'(COUNT_READY - 1);
    localparam logic [31:0] SET_LAST     = 32'(COUNT_SET - 1);
    localparam logic [31:0] GO_LAST      = 32'(COUNT_GO - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(COUNT_TIMEOUT - 1);
    localparam logic [31:0] BLINK_LAST   = 32'(BLINK_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_SET,
        S_GO,
        S_TIMING,
        S_FINISH,
        S_FALSE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic               r_set_prev;
    logic               r_abort_prev;
    logic [N_LANES-1:0] r_meta_prev;
    logic [N_LANES-1:0] r_active;
    logic [N_LANES-1:0] r_finished;
    logic [N_LANES-1:0] r_pending;
    logic [N_LANES-1:0] r_false_start;
    logic [31:0]        r_phase_cnt;
    logic [31:0]        r_race_cnt;
    logic               r_blink;
    logic               r_tx_start;
    logic [LANE_W-1:0]  r_tx_lane;

    logic               w_set_edge;
    logic               w_abort_edge;
    logic [N_LANES-1:0] w_meta_edge;
    logic               w_in_race;
    logic               w_prestart;
    logic               w_arm;
    logic [N_LANES-1:0] w_fs_hit;
    logic [N_LANES-1:0] w_meta_hit;
    logic [N_LANES-1:0] w_finished_nxt;
    logic               w_all_done;
    logic               w_timeout;
    logic               w_tx_fire;
    logic [LANE_W-1:0]  w_tx_idx;
    logic [N_LANES-1:0] w_tx_low;
    logic [N_LANES-1:0] w_tx_clr;

    assign w_set_edge     = set_button_in & ~r_set_prev;
    assign w_abort_edge   = abort_button_in & ~r_abort_prev;
    assign w_meta_edge    = sensor_meta_in & ~r_meta_prev;
    assign w_in_race      = (r_state == S_GO) || (r_state == S_TIMING);
    assign w_prestart     = (r_state == S_READY) || (r_state == S_SET);
    assign w_arm          = (r_state == S_IDLE) && w_set_edge && (lane_active_in != '0)
                            && !w_abort_edge;
    assign w_fs_hit       = sensor_start_in & r_active;
    assign w_meta_hit     = w_in_race ? (w_meta_edge & r_active & ~r_finished) : '0;
    assign w_finished_nxt = r_finished | w_meta_hit;
    assign w_all_done     = w_in_race && (w_finished_nxt == r_active);
    assign w_timeout      = w_in_race && (r_race_cnt == TIMEOUT_LAST);

    // Next-state decode; abort overrides every other transition outside idle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_arm) w_next_state = S_READY;
            S_READY: begin
                if (w_fs_hit != '0)               w_next_state = S_FALSE;
                else if (r_phase_cnt == READY_LAST) w_next_state = S_SET;
            end
            S_SET: begin
                if (w_fs_hit != '0)             w_next_state = S_FALSE;
                else if (r_phase_cnt == SET_LAST) w_next_state = S_GO;
            end
            S_GO: begin
                if (w_all_done || w_timeout)     w_next_state = S_FINISH;
                else if (r_phase_cnt == GO_LAST) w_next_state = S_TIMING;
            end
            S_TIMING: if (w_all_done || w_timeout) w_next_state = S_FINISH;
            S_FINISH: if (w_set_edge) w_next_state = S_IDLE;
            S_FALSE:  if (w_set_edge) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
        if (w_abort_edge && (r_state != S_IDLE)) w_next_state = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_global) begin
        if (!reset_global) r_state <= S_IDLE;
        else               r_state <= w_next_state;
    end

    // Previous-level registers for rising-edge detection.
    always_ff @(posedge clk or negedge reset_global) begin
        if (!reset_global) begin
            r_set_prev   <= 1'b0;
            r_abort_prev <= 1'b0;
            r_meta_prev  <= '0;
        end else begin
            r_set_prev   <= set_button_in;
            r_abort_prev <= abort_button_in;
            r_meta_prev  <= sensor_meta_in;
        end
    end

    // Phase counter restarts on every state entry and wraps per blink half-period in S_FALSE;
    // race counter starts on S_GO entry and runs through S_TIMING.
    always_ff @(posedge clk or negedge reset_global) begin
        if (!reset_global) begin
            r_phase_cnt <= '0;
            r_race_cnt  <= '0;
            r_blink     <= 1'b0;
        end else begin
            if (w_next_state != r_state)
                r_phase_cnt <= '0;
            else if ((r_state == S_FALSE) && (r_phase_cnt == BLINK_LAST))
                r_phase_cnt <= '0;
            else if (w_prestart || w_in_race || (r_state == S_FALSE))
                r_phase_cnt <= r_phase_cnt + 32'd1;

            if ((r_state != S_GO) && (w_next_state == S_GO))
                r_race_cnt <= '0;
            else if (w_in_race)
                r_race_cnt <= r_race_cnt + 32'd1;

            if ((r_state != S_FALSE) && (w_next_state == S_FALSE))
                r_blink <= 1'b1;
            else if ((r_state == S_FALSE) && (r_phase_cnt == BLINK_LAST))
                r_blink <= ~r_blink;
        end
    end

    // Lowest pending lane is reported first.
    always_comb begin
        w_tx_idx = '0;
        w_tx_low = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_tx_idx    = LANE_W'(i);
                w_tx_low    = '0;
                w_tx_low[i] = 1'b1;
            end
        end
    end

    // The r_tx_start term forces an idle cycle so a one-cycle-late busy is still honoured.
    assign w_tx_fire = (r_pending != '0) && !uart_busy_in && !r_tx_start
                       && (w_in_race || (r_state == S_FINISH))
                       && (w_next_state != S_IDLE);
    assign w_tx_clr  = w_tx_fire ? w_tx_low : '0;

    // Per-lane bookkeeping: participation, finish capture, report queue, false-start flags.
    always_ff @(posedge clk or negedge reset_global) begin
        if (!reset_global) begin
            r_active      <= '0;
            r_finished    <= '0;
            r_pending     <= '0;
            r_false_start <= '0;
        end else if (w_arm) begin
            r_active      <= lane_active_in;
            r_finished    <= '0;
            r_pending     <= '0;
            r_false_start <= '0;
        end else begin
            r_finished <= w_finished_nxt;
            if (w_next_state == S_IDLE) begin
                r_pending     <= '0;
                r_false_start <= '0;
            end else begin
                r_pending <= (r_pending | w_meta_hit) & ~w_tx_clr;
                if (w_prestart) r_false_start <= r_false_start | w_fs_hit;
            end
        end
    end

    // Registered UART report request.
    always_ff @(posedge clk or negedge reset_global) begin
        if (!reset_global) begin
            r_tx_start <= 1'b0;
            r_tx_lane  <= '0;
        end else begin
            r_tx_start <= w_tx_fire;
            if (w_tx_fire) r_tx_lane <= w_tx_idx;
        end
    end

    // Moore output decode from state and lane registers.
    always_comb begin
        reset_timer_out  = 1'b0;
        enable_timer_out = '0;
        semaforo_out     = 3'b000;
        servo_out        = 1'b0;
        race_done_out    = 1'b0;
        case (r_state)
            S_IDLE:   reset_timer_out = 1'b1;
            S_READY:  semaforo_out = 3'b001;
            S_SET:    semaforo_out = 3'b010;
            S_GO: begin
                semaforo_out     = 3'b100;
                servo_out        = 1'b1;
                enable_timer_out = r_active & ~r_finished;
            end
            S_TIMING: enable_timer_out = r_active & ~r_finished;
            S_FINISH: race_done_out = 1'b1;
            S_FALSE:  semaforo_out = {2'b00, r_blink};
            default:  reset_timer_out = 1'b0;
        endcase
    end

    assign false_start_out = r_false_start;
    assign tx_start_out    = r_tx_start;
    assign tx_lane_out     = r_tx_lane;

endmodule

// File: tb/tb_fsm_control_multilane.sv
// tb/tb_fsm_control_multilane.sv - directed self-checking bench for fsm_control_multilane
module tb_fsm_control_multilane;

    logic       clk = 1'b0;
    logic       reset_global;
    logic       set_button_in;
    logic       abort_button_in;
    logic [3:0] lane_active_in;
    logic [3:0] sensor_start_in;
    logic [3:0] sensor_meta_in;
    logic       uart_busy_in;
    logic       reset_timer_out;
    logic [3:0] enable_timer_out;
    logic [2:0] semaforo_out;
    logic       servo_out;
    logic [3:0] false_start_out;
    logic       race_done_out;
    logic       tx_start_out;
    logic [1:0] tx_lane_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tx_lanes[$];
    int tx_cycles[$];

    fsm_control_multilane #(
        .N_LANES(4), .CLK_FREQ(8), .COUNT_READY(16), .COUNT_SET(16),
        .COUNT_GO(8), .COUNT_TIMEOUT(100), .BLINK_HALF(2)
    ) dut (
        .clk(clk), .reset_global(reset_global), .set_button_in(set_button_in),
        .abort_button_in(abort_button_in), .lane_active_in(lane_active_in),
        .sensor_start_in(sensor_start_in), .sensor_meta_in(sensor_meta_in),
        .uart_busy_in(uart_busy_in), .reset_timer_out(reset_timer_out),
        .enable_timer_out(enable_timer_out), .semaforo_out(semaforo_out),
        .servo_out(servo_out), .false_start_out(false_start_out),
        .race_done_out(race_done_out), .tx_start_out(tx_start_out),
        .tx_lane_out(tx_lane_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start_out) begin
            tx_lanes.push_back(int'(tx_lane_out));
            tx_cycles.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_race(input logic [3:0] act);
        lane_active_in = act;
        set_button_in  = 1'b1;
        tick(1);
        set_button_in  = 1'b0;
        tick(32);
    endtask

    task automatic abort_race();
        abort_button_in = 1'b1;
        tick(1);
        abort_button_in = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        tick(3);
        n_checks++;
        if (reset_timer_out !== 1'b1 || enable_timer_out !== 4'b0 || semaforo_out !== 3'b0 ||
            servo_out !== 1'b0 || false_start_out !== 4'b0 || race_done_out !== 1'b0 ||
            tx_start_out !== 1'b0 || tx_lane_out !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_values: rt=%b en=%b sem=%b servo=%b fs=%b done=%b tx=%b lane=%0d, expected rt=1 rest 0",
                     reset_timer_out, enable_timer_out, semaforo_out, servo_out, false_start_out,
                     race_done_out, tx_start_out, tx_lane_out);
        end
        @(negedge clk);
        reset_global = 1'b1;
        tick(2);
    endtask

    task automatic test_nominal();
        int bad;
        lane_active_in = 4'b0101;
        set_button_in  = 1'b1;
        tick(1);
        set_button_in  = 1'b0;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (semaforo_out !== 3'b001) bad++;
            tick(1);
        end
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL ready_red: bad cycles %0d, expected 0", bad); end
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (semaforo_out !== 3'b010) bad++;
            tick(1);
        end
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL set_yellow: bad cycles %0d, expected 0", bad); end
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (semaforo_out !== 3'b100 || servo_out !== 1'b1 || enable_timer_out !== 4'b0101) bad++;
            tick(1);
        end
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL go_green: bad cycles %0d, expected 0", bad); end
        n_checks++;
        if (semaforo_out !== 3'b000 || enable_timer_out !== 4'b0101) begin
            n_errors++;
            $display("FAIL timing_enable: sem=%b en=%b, expected sem=000 en=0101", semaforo_out, enable_timer_out);
        end
        tx_lanes.delete(); tx_cycles.delete();
        sensor_meta_in = 4'b0100;
        tick(1);
        n_checks++;
        if (enable_timer_out !== 4'b0001) begin
            n_errors++; $display("FAIL meta2_drop: en=%b, expected 0001", enable_timer_out);
        end
        tick(2);
        sensor_meta_in = 4'b0101;
        tick(1);
        n_checks++;
        if (enable_timer_out !== 4'b0000 || race_done_out !== 1'b1) begin
            n_errors++; $display("FAIL nominal_finish: en=%b done=%b, expected 0000 1", enable_timer_out, race_done_out);
        end
        tick(4);
        n_checks++;
        if (tx_lanes.size() !== 2 || tx_lanes[0] !== 2 || tx_lanes[1] !== 0) begin
            n_errors++; $display("FAIL nominal_tx: got %p, expected '{2,0}", tx_lanes);
        end
        sensor_meta_in = 4'b0000;
        set_button_in  = 1'b1;
        tick(1);
        set_button_in  = 1'b0;
        n_checks++;
        if (reset_timer_out !== 1'b1 || race_done_out !== 1'b0) begin
            n_errors++; $display("FAIL finish_to_idle: rt=%b done=%b, expected 1 0", reset_timer_out, race_done_out);
        end
        tick(1);
    endtask

    task automatic test_false_start();
        int bad;
        logic exp_red;
        lane_active_in = 4'b0001;
        set_button_in  = 1'b1;
        tick(1);
        set_button_in  = 1'b0;
        tick(19);
        sensor_start_in = 4'b0001;
        tick(1);
        n_checks++;
        if (false_start_out !== 4'b0001) begin
            n_errors++; $display("FAIL fs_flag: fs=%b, expected 0001", false_start_out);
        end
        sensor_start_in = 4'b0000;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            exp_red = ((k / 2) % 2) == 0;
            if (semaforo_out !== {2'b00, exp_red} || enable_timer_out !== 4'b0) bad++;
            tick(1);
        end
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL fs_blink: bad cycles %0d, expected 0", bad); end
        set_button_in = 1'b1;
        tick(1);
        set_button_in = 1'b0;
        n_checks++;
        if (false_start_out !== 4'b0000 || reset_timer_out !== 1'b1) begin
            n_errors++; $display("FAIL fs_clear: fs=%b rt=%b, expected 0000 1", false_start_out, reset_timer_out);
        end
        tick(1);
    endtask

    task automatic test_timeout();
        start_race(4'b1111);
        tx_lanes.delete(); tx_cycles.delete();
        tick(10);
        sensor_meta_in = 4'b0010;
        tick(89);
        n_checks++;
        if (race_done_out !== 1'b0 || enable_timer_out !== 4'b1101) begin
            n_errors++; $display("FAIL pre_timeout: done=%b en=%b, expected 0 1101", race_done_out, enable_timer_out);
        end
        tick(1);
        n_checks++;
        if (race_done_out !== 1'b1 || enable_timer_out !== 4'b0000) begin
            n_errors++; $display("FAIL timeout: done=%b en=%b, expected 1 0000", race_done_out, enable_timer_out);
        end
        tick(3);
        n_checks++;
        if (tx_lanes.size() !== 1 || tx_lanes[0] !== 1) begin
            n_errors++; $display("FAIL timeout_tx: got %p, expected '{1}", tx_lanes);
        end
        sensor_meta_in = 4'b0000;
        set_button_in  = 1'b1;
        tick(1);
        set_button_in  = 1'b0;
        tick(1);
    endtask

    task automatic test_back_to_back();
        start_race(4'b1111);
        tick(2);
        tx_lanes.delete(); tx_cycles.delete();
        uart_busy_in   = 1'b1;
        sensor_meta_in = 4'b1010;
        tick(5);
        n_checks++;
        if (tx_lanes.size() !== 0) begin
            n_errors++; $display("FAIL busy_hold: pulses %0d, expected 0", tx_lanes.size());
        end
        uart_busy_in = 1'b0;
        tick(6);
        n_checks++;
        if (tx_lanes.size() !== 2 || tx_lanes[0] !== 1 || tx_lanes[1] !== 3 ||
            (tx_cycles[1] - tx_cycles[0]) < 2) begin
            n_errors++; $display("FAIL simul_tx: got %p cycles %p, expected '{1,3} gap>=2", tx_lanes, tx_cycles);
        end
        sensor_meta_in = 4'b0000;
        abort_race();
        n_checks++;
        if (reset_timer_out !== 1'b1 || enable_timer_out !== 4'b0) begin
            n_errors++; $display("FAIL abort_idle: rt=%b en=%b, expected 1 0000", reset_timer_out, enable_timer_out);
        end
    endtask

    task automatic test_abort();
        start_race(4'b0011);
        tick(8);
        tx_lanes.delete(); tx_cycles.delete();
        sensor_meta_in  = 4'b0001;
        abort_button_in = 1'b1;
        set_button_in   = 1'b1;
        tick(1);
        n_checks++;
        if (reset_timer_out !== 1'b1 || semaforo_out !== 3'b0 || enable_timer_out !== 4'b0) begin
            n_errors++; $display("FAIL abort_set_idle: rt=%b sem=%b en=%b, expected 1 000 0000",
                                 reset_timer_out, semaforo_out, enable_timer_out);
        end
        abort_button_in = 1'b0;
        set_button_in   = 1'b0;
        sensor_meta_in  = 4'b0000;
        tick(4);
        n_checks++;
        if (tx_lanes.size() !== 0 || reset_timer_out !== 1'b1) begin
            n_errors++; $display("FAIL abort_no_tx: pulses %0d rt=%b, expected 0 1", tx_lanes.size(), reset_timer_out);
        end
    endtask

    task automatic test_async_reset();
        lane_active_in = 4'b0011;
        set_button_in  = 1'b1;
        tick(1);
        set_button_in  = 1'b0;
        tick(20);
        n_checks++;
        if (semaforo_out !== 3'b010) begin
            n_errors++; $display("FAIL pre_reset_set: sem=%b, expected 010", semaforo_out);
        end
        reset_global = 1'b0;
        #1;
        n_checks++;
        if (reset_timer_out !== 1'b1 || enable_timer_out !== 4'b0 || semaforo_out !== 3'b0 ||
            servo_out !== 1'b0 || false_start_out !== 4'b0 || race_done_out !== 1'b0 ||
            tx_start_out !== 1'b0 || tx_lane_out !== 2'd0) begin
            n_errors++;
            $display("FAIL async_reset: rt=%b en=%b sem=%b servo=%b fs=%b done=%b tx=%b lane=%0d, expected rt=1 rest 0",
                     reset_timer_out, enable_timer_out, semaforo_out, servo_out, false_start_out,
                     race_done_out, tx_start_out, tx_lane_out);
        end
        @(negedge clk);
        reset_global = 1'b1;
        tick(2);
        n_checks++;
        if (reset_timer_out !== 1'b1 || semaforo_out !== 3'b0) begin
            n_errors++; $display("FAIL post_reset_idle: rt=%b sem=%b, expected 1 000", reset_timer_out, semaforo_out);
        end
    endtask

    task automatic test_edge_cases();
        lane_active_in = 4'b0000;
        set_button_in  = 1'b1;
        tick(1);
        set_button_in  = 1'b0;
        tick(3);
        n_checks++;
        if (reset_timer_out !== 1'b1 || semaforo_out !== 3'b0) begin
            n_errors++; $display("FAIL zero_active: rt=%b sem=%b, expected 1 000", reset_timer_out, semaforo_out);
        end
        tx_lanes.delete(); tx_cycles.delete();
        sensor_meta_in = 4'b1111;
        tick(1);
        sensor_meta_in = 4'b0000;
        tick(3);
        n_checks++;
        if (tx_lanes.size() !== 0) begin
            n_errors++; $display("FAIL idle_meta: pulses %0d, expected 0", tx_lanes.size());
        end
        start_race(4'b0001);
        sensor_meta_in = 4'b0100;
        tick(1);
        n_checks++;
        if (enable_timer_out !== 4'b0001) begin
            n_errors++; $display("FAIL inactive_meta_en: en=%b, expected 0001", enable_timer_out);
        end
        tick(4);
        n_checks++;
        if (tx_lanes.size() !== 0 || race_done_out !== 1'b0) begin
            n_errors++; $display("FAIL inactive_meta_tx: pulses %0d done=%b, expected 0 0", tx_lanes.size(), race_done_out);
        end
        sensor_meta_in = 4'b0000;
        abort_race();
    endtask

    initial begin
        reset_global    = 1'b0;
        set_button_in   = 1'b0;
        abort_button_in = 1'b0;
        lane_active_in  = 4'b0;
        sensor_start_in = 4'b0;
        sensor_meta_in  = 4'b0;
        uart_busy_in    = 1'b0;
        test_reset();
        test_nominal();
        test_false_start();
        test_timeout();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_edge_cases();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
